// File: rtl/mod_digest_reader_if.sv
// Memory read port and byte-stream handshake for the digest reader.
// master = reader side, slave = memory/host side.
interface mod_digest_reader_if #(
  parameter int ADDR_W = 7
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rd_data;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output mem_rd_en,
    output mem_addr,
    output out_data,
    output out_valid,
    output out_last,
    input  mem_rd_data,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    input  out_data,
    input  out_valid,
    input  out_last,
    output mem_rd_data,
    output out_ready
  );
endinterface

// File: rtl/mod_digest_reader.sv
// Reads H0..H7 from the H/K memory and streams the 32-byte digest
// big-endian over a valid/ready byte interface.
module mod_digest_reader #(
  parameter int ADDR_W = 7,
  parameter int H_BASE = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  mod_digest_reader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_SEND,
    S_FINISH
  } state_e;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(H_BASE);

  state_e            state_q;
  logic [2:0]        word_idx_q;
  logic [1:0]        byte_idx_q;
  logic [31:0]       word_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;
  logic [7:0]        out_byte;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            word_idx_q <= '0;
            byte_idx_q <= '0;
            addr_q     <= BASE;
            rd_en_q    <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_READ;
          end
        end
        S_READ: begin
          state_q <= S_LATCH;
        end
        S_LATCH: begin
          word_q  <= bus.mem_rd_data;
          valid_q <= 1'b1;
          last_q  <= 1'b0;
          state_q <= S_SEND;
        end
        S_SEND: begin
          if (bus.out_ready) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            last_q     <= (word_idx_q == 3'd7) &&
                          (byte_idx_q == 2'd2);
            if (byte_idx_q == 2'd3) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              if (word_idx_q == 3'd7) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_FINISH;
              end else begin
                word_idx_q <= word_idx_q + 3'd1;
                addr_q     <= BASE +
                              ADDR_W'(word_idx_q + 3'd1);
                rd_en_q    <= 1'b1;
                state_q    <= S_READ;
              end
            end
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // byte 0 is bank_1, the most significant byte
  always_comb begin
    out_byte = word_q[31:24];
    unique case (byte_idx_q)
      2'd0: out_byte = word_q[31:24];
      2'd1: out_byte = word_q[23:16];
      2'd2: out_byte = word_q[15:8];
      2'd3: out_byte = word_q[7:0];
      default: out_byte = word_q[31:24];
    endcase
  end

  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.out_data  = out_byte;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule
